// File: rtl/rocket_core_mem_arb.sv
// Round-robin arbiter sharing one registered downstream memory request channel
// among N_REQ cores; an in-order ID FIFO routes responses back to their source.
module rocket_core_mem_arb #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      out_we,
    output logic [DATA_W-1:0]         out_wdata,
    output logic [$clog2(N_REQ)-1:0]  out_src,
    input  logic                      in_resp_valid,
    input  logic [DATA_W-1:0]         in_resp_data,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      resp_err
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W-1:0] idx;
    int               idx_i;
    logic             found;
    logic             load;
    logic             accept;
    logic             pop;
    logic             spurious;

    logic [SRC_W-1:0] id_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [SRC_W-1:0] head;

    assign outstanding = count;
    assign head        = id_mem[rd_ptr];

    // A pop in the same cycle deliberately does not free a slot: load only sees the registered count.
    assign load     = (!out_valid || out_ready) && (count < CNT_W'(DEPTH));
    assign accept   = load && found && !reset;
    assign pop      = in_resp_valid && (count != '0) && !reset;
    assign spurious = in_resp_valid && (count == '0);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_i  = 0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_i = (int'(ptr) + k) % N_REQ;
            idx   = SRC_W'(idx_i);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
        resp_valid = '0;
        if (pop) resp_valid[head] = 1'b1;
    end

    assign resp_data = in_resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_we    <= 1'b0;
            out_wdata <= '0;
            out_src   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
                out_we    <= req_we[winner];
                out_wdata <= req_wdata[winner*DATA_W +: DATA_W];
                out_src   <= winner;
                ptr       <= (winner == SRC_W'(N_REQ - 1)) ? '0 : winner + SRC_W'(1);
                wr_ptr    <= wr_ptr + PTR_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (spurious) resp_err <= 1'b1;
        end
    end

    // NOTE: storage has no reset; validity is tracked entirely by count and the pointers.
    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_ptr] <= winner;
    end

endmodule

// File: doc/rocket_core_mem_arb.md
Name: rocket_core_mem_arb

Overview:
- Round-robin arbiter that shares one downstream memory request channel among the four Rocket core BFM request ports in the SoC subsystem testbench.
- Registers the selected request into a single output stage.
- Records the source core of each accepted request in an in-order ID FIFO, and uses it to route in-order downstream responses back to the originating core.

Parameters:
- N_REQ, 4, number of requesting cores (2..8)
- ADDR_W, 32, request address width
- DATA_W, 64, write/read data width
- DEPTH, 4, maximum outstanding requests (ID FIFO depth, power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-core request valid
- req_ready  out  N_REQ  per-core request accept
- req_addr  in  N_REQ*ADDR_W  per-core address; core i at slice [i*ADDR_W +: ADDR_W]
- req_we  in  N_REQ  per-core write enable
- req_wdata  in  N_REQ*DATA_W  per-core write data
- out_valid  out  1  downstream request valid (registered)
- out_ready  in  1  downstream accept
- out_addr  out  ADDR_W  registered address
- out_we  out  1  registered write enable
- out_wdata  out  DATA_W  registered write data
- out_src  out  $clog2(N_REQ)  source core of the registered request
- in_resp_valid  in  1  downstream response, strictly in request order, always accepted
- in_resp_data  in  DATA_W  response data
- resp_valid  out  N_REQ  per-core response valid
- resp_data  out  DATA_W  response data, broadcast to all cores
- outstanding  out  $clog2(DEPTH)+1  ID FIFO occupancy
- resp_err  out  1  sticky spurious-response flag

Behaviour:
- Reset (async, active-high) values:
  - out_valid=0; out_addr/out_we/out_wdata/out_src=0.
  - RR pointer=0; FIFO rd/wr pointers=0; outstanding=0; resp_err=0.
  - req_ready=0 and resp_valid=0 while reset is asserted.
- Load condition: load = (!out_valid || out_ready) && (outstanding < DEPTH).
- Arbitration (combinational):
  - Scan indices ptr, ptr+1, …, ptr+N_REQ-1 (mod N_REQ); the first index with req_valid set wins.
  - req_ready[i] = load && (winner==i). At most one req_ready is high per cycle.
  - req_ready does not depend on out_ready except through load.
- Accept (req_valid[i] && req_ready[i]) at cycle t:
  - Output register takes core i's addr/we/wdata and out_src=i.
  - out_valid=1 from t+1. Latency is 1 cycle.
  - i is pushed into the ID FIFO at t.
  - ptr <= (i+1) mod N_REQ.
  - ptr is unchanged on any cycle with no accept.
- Output hold: while out_valid && !out_ready, all out_* stay stable and no new grant is issued.
- Output drain: out_valid && out_ready with no accept that cycle -> out_valid=0 next cycle.
- Back-to-back: accept and downstream handshake in the same cycle -> output register reloads, out_valid stays 1, giving full throughput.
- FIFO full: at outstanding==DEPTH, load=0. A pop in that same cycle does NOT free a slot for that cycle; the accept occurs the next cycle at the earliest.
- Response routing (combinational, same cycle):
  - resp_valid[head] = in_resp_valid && outstanding!=0; all other bits 0.
  - resp_data = in_resp_data.
  - The FIFO pops on the same cycle.
- Spurious response: in_resp_valid && outstanding==0 sets resp_err=1. No resp_valid is driven and no pop occurs. resp_err clears only on reset.
- Simultaneous push and pop: occupancy unchanged; the FIFO pointers both advance and wrap mod DEPTH.
- Reset mid-operation: all in-flight requests and IDs are discarded immediately (async). Late downstream responses arriving after reset set resp_err.

Test Plan:
- Reset check: assert reset mid-stream with out_valid=1 and outstanding=3 -> out_valid=0, outstanding=0, req_ready=0, resp_err=0, all asynchronously.
- Single requester: core 2 requests addr 0x1000, we=0, out_ready=1 -> out_valid at t+1 with out_addr=0x1000, out_src=2. A response of 0xDEAD -> resp_valid=4'b0100, resp_data=0xDEAD.
- Round-robin fairness: all 4 cores hold req_valid, out_ready=1, responses returned promptly -> grant order 0,1,2,3,0,1 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles after a grant to core 1 -> out_* stable, req_ready all 0. Release -> next grant goes to core 2.
- FIFO full: DEPTH=4, no responses, 5 requests -> 4 accepted, outstanding=4, req_ready=0. One response plus a pending request in the same cycle -> accept occurs the following cycle.
- Spurious response: in_resp_valid with outstanding=0 -> resp_err=1, resp_valid=0. resp_err remains 1 until reset.
